// File: rtl/branch_resolver_pkg.sv
// Shared types and constants for the EX-stage branch resolver and its
// in-flight prediction FIFO.
package branch_resolver_pkg;

  localparam int DATA_WID = 32;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  typedef struct packed {
    logic [DATA_WID-1:0] pc;
    logic                predict;
    logic [DATA_WID-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/pred_fifo.sv
// In-order FIFO of IF-issued predictions awaiting resolution in EX.
// Flush empties the FIFO and overrides a same-cycle push.
module pred_fifo
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  pred_entry_t            push_data,
  input  logic                   pop,
  input  logic                   flush,
  output pred_entry_t            head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pred_entry_t   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is not reset; validity is tracked by the pointers
  // and count alone, which keeps the array as plain flops/RAM without reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: pops the oldest prediction, computes the real
// outcome, flags mispredicts and feeds the registered old_* bus to the predictor.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = DATA_WID,  // must equal DATA_WID (entry struct width)
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid,
  input  logic [XLEN-1:0]  push_pc,
  input  logic             push_predict,
  input  logic [XLEN-1:0]  push_target,
  output logic             full,
  input  logic             ex_valid,
  input  logic             ex_cond,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic [XLEN-1:0]  ex_target,
  output logic [XLEN-1:0]  old_pc,
  output logic [XLEN-1:0]  old_branch_pc,
  output logic             old_predict,
  output logic             old_actual,
  output logic             old_branch,
  output logic             redirect,
  output logic             err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  pred_entry_t   push_entry;
  pred_entry_t   head;
  logic [CW-1:0] count;
  logic          empty;
  logic          pop;
  logic          actual;
  logic          bad_funct3;
  logic          miss;
  logic          target_only_miss;
  logic [XLEN-1:0] correct_pc;

  assign push_entry = '{pc: push_pc, predict: push_predict, target: push_target};
  assign full       = (count == CW'(DEPTH));
  assign empty      = (count == '0);
  assign pop        = ex_valid && !empty;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_valid),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (miss),
    .head      (head),
    .count     (count)
  );

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    actual     = 1'b1;
    bad_funct3 = 1'b0;
    if (ex_cond) begin
      unique case (ex_funct3)
        BEQ:     actual = (ex_rs1 == ex_rs2);
        BNE:     actual = (ex_rs1 != ex_rs2);
        BLT:     actual = ($signed(ex_rs1) <  $signed(ex_rs2));
        BGE:     actual = ($signed(ex_rs1) >= $signed(ex_rs2));
        BLTU:    actual = (ex_rs1 <  ex_rs2);
        BGEU:    actual = (ex_rs1 >= ex_rs2);
        default: begin
          actual     = 1'b0;
          bad_funct3 = 1'b1;
        end
      endcase
    end
  end

  assign correct_pc       = actual ? ex_target : head.pc + XLEN'(4);
  assign target_only_miss = actual && head.predict && (ex_target != head.target);
  assign miss             = pop && ((actual != head.predict) || target_only_miss);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      old_pc        <= '0;
      old_branch_pc <= '0;
      old_predict   <= 1'b0;
      old_actual    <= 1'b0;
      old_branch    <= 1'b0;
      redirect      <= 1'b0;
      err           <= 1'b0;
      branch_cnt    <= '0;
      miss_cnt      <= '0;
    end else begin
      old_branch <= pop && ex_cond;
      redirect   <= miss;
      if (pop) begin
        old_branch_pc <= head.pc;
        old_pc        <= correct_pc;
        old_actual    <= actual;
        // A target-only miss must still look like a direction fail upstream.
        old_predict   <= target_only_miss ? !actual : head.predict;
      end else begin
        old_predict   <= old_actual;
      end
      if ((push_valid && full && !pop) || (ex_valid && empty) ||
          (pop && ex_cond && bad_funct3))
        err <= 1'b1;
      if (pop && ex_cond && (branch_cnt != '1))
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (miss && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver (DEPTH=4, counters 4 bits
// wide so saturation is reachable).
module tb_branch_resolver;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid;
  logic [XLEN-1:0]  push_pc;
  logic             push_predict;
  logic [XLEN-1:0]  push_target;
  logic             full;
  logic             ex_valid;
  logic             ex_cond;
  logic [2:0]       ex_funct3;
  logic [XLEN-1:0]  ex_rs1;
  logic [XLEN-1:0]  ex_rs2;
  logic [XLEN-1:0]  ex_target;
  logic [XLEN-1:0]  old_pc;
  logic [XLEN-1:0]  old_branch_pc;
  logic             old_predict;
  logic             old_actual;
  logic             old_branch;
  logic             redirect;
  logic             err;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolver #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .push_valid    (push_valid),
    .push_pc       (push_pc),
    .push_predict  (push_predict),
    .push_target   (push_target),
    .full          (full),
    .ex_valid      (ex_valid),
    .ex_cond       (ex_cond),
    .ex_funct3     (ex_funct3),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_target     (ex_target),
    .old_pc        (old_pc),
    .old_branch_pc (old_branch_pc),
    .old_predict   (old_predict),
    .old_actual    (old_actual),
    .old_branch    (old_branch),
    .redirect      (redirect),
    .err           (err),
    .branch_cnt    (branch_cnt),
    .miss_cnt      (miss_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    push_valid = 0; push_pc = '0; push_predict = 0; push_target = '0;
    ex_valid = 0; ex_cond = 0; ex_funct3 = '0; ex_rs1 = '0; ex_rs2 = '0;
    ex_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic push(input logic [XLEN-1:0] pc, input logic pred,
                      input logic [XLEN-1:0] tgt);
    push_valid = 1; push_pc = pc; push_predict = pred; push_target = tgt;
    tick();
    push_valid = 0;
  endtask

  task automatic resolve(input logic cond, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] tgt);
    ex_valid = 1; ex_cond = cond; ex_funct3 = f3; ex_rs1 = a; ex_rs2 = b;
    ex_target = tgt;
    tick();
    ex_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++;
    if ({full, old_predict, old_actual, old_branch, redirect, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 000000",
               {full, old_predict, old_actual, old_branch, redirect, err});
    end
    checks++;
    if (old_pc !== 0 || old_branch_pc !== 0 || branch_cnt !== 0 || miss_cnt !== 0) begin
      errors++;
      $display("FAIL reset_regs got pc=%h bpc=%h bc=%0d mc=%0d want all 0",
               old_pc, old_branch_pc, branch_cnt, miss_cnt);
    end
  endtask

  task automatic test_bne_hit();
    do_reset();
    push(32'h100, 1'b0, 32'h104);
    tick();
    resolve(1'b1, 3'b001, 32'd5, 32'd5, 32'h200);
    checks++;
    if ({old_actual, old_predict, old_branch, redirect} !== 4'b0010) begin
      errors++;
      $display("FAIL bne_flags got act/pred/br/redir=%b want 0010",
               {old_actual, old_predict, old_branch, redirect});
    end
    checks++;
    if (old_pc !== 32'h104 || old_branch_pc !== 32'h100) begin
      errors++;
      $display("FAIL bne_pc got pc=%h bpc=%h want 104/100", old_pc, old_branch_pc);
    end
    checks++;
    if (branch_cnt !== 4'd1 || miss_cnt !== 4'd0) begin
      errors++;
      $display("FAIL bne_cnt got bc=%0d mc=%0d want 1/0", branch_cnt, miss_cnt);
    end
    tick();
    checks++;
    if (old_branch !== 0 || redirect !== 0 || old_predict !== old_actual ||
        old_pc !== 32'h104 || err !== 0) begin
      errors++;
      $display("FAIL bne_idle got br=%b redir=%b pred=%b act=%b pc=%h err=%b want 0 0 eq eq 104 0",
               old_branch, redirect, old_predict, old_actual, old_pc, err);
    end
  endtask

  task automatic test_mispredict_flush();
    do_reset();
    push(32'h200, 1'b0, 32'h204);
    push(32'h204, 1'b0, 32'h208);
    push(32'h208, 1'b0, 32'h20C);
    checks++;
    if (full !== 0) begin
      errors++;
      $display("FAIL mp_full3 got %b want 0", full);
    end
    // Resolve with a wrong-path push in the same cycle; both are discarded.
    push_valid = 1; push_pc = 32'h20C; push_predict = 0; push_target = 32'h210;
    resolve(1'b1, 3'b100, 32'hFFFF_FFFF, 32'd1, 32'h240);
    push_valid = 0;
    checks++;
    if ({old_actual, old_predict, redirect, old_branch} !== 4'b1011 || old_pc !== 32'h240) begin
      errors++;
      $display("FAIL mp_out got act/pred/redir/br=%b pc=%h want 1011 240",
               {old_actual, old_predict, redirect, old_branch}, old_pc);
    end
    checks++;
    if (branch_cnt !== 4'd1 || miss_cnt !== 4'd1 || err !== 0) begin
      errors++;
      $display("FAIL mp_cnt got bc=%0d mc=%0d err=%b want 1 1 0", branch_cnt, miss_cnt, err);
    end
    resolve(1'b1, 3'b000, 32'd0, 32'd0, 32'h300);
    checks++;
    if (err !== 1 || redirect !== 0 || old_branch !== 0 || old_pc !== 32'h240) begin
      errors++;
      $display("FAIL mp_empty got err=%b redir=%b br=%b pc=%h want 1 0 0 240",
               err, redirect, old_branch, old_pc);
    end
    tick();
    checks++;
    if (err !== 1) begin
      errors++;
      $display("FAIL mp_sticky got err=%b want 1", err);
    end
  endtask

  task automatic test_jalr_target();
    do_reset();
    push(32'h300, 1'b1, 32'h400);
    resolve(1'b0, 3'b000, 32'd0, 32'd0, 32'h500);
    checks++;
    if ({redirect, old_actual, old_predict, old_branch} !== 4'b1100 ||
        old_pc !== 32'h500 || old_branch_pc !== 32'h300) begin
      errors++;
      $display("FAIL jalr_miss got redir/act/pred/br=%b pc=%h bpc=%h want 1100 500 300",
               {redirect, old_actual, old_predict, old_branch}, old_pc, old_branch_pc);
    end
    checks++;
    if (miss_cnt !== 4'd1 || branch_cnt !== 4'd0) begin
      errors++;
      $display("FAIL jalr_cnt got mc=%0d bc=%0d want 1 0", miss_cnt, branch_cnt);
    end
    push(32'h310, 1'b1, 32'h380);
    resolve(1'b0, 3'b000, 32'd0, 32'd0, 32'h380);
    checks++;
    if ({redirect, old_actual, old_predict} !== 3'b011 || old_pc !== 32'h380 ||
        miss_cnt !== 4'd1) begin
      errors++;
      $display("FAIL jal_hit got redir/act/pred=%b pc=%h mc=%0d want 011 380 1",
               {redirect, old_actual, old_predict}, old_pc, miss_cnt);
    end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3 [11] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b100, 3'b101,
                             3'b101, 3'b110, 3'b110, 3'b111, 3'b111};
    logic [31:0] a  [11] = '{32'd7, 32'd7, 32'd7, 32'hFFFF_FFFF, 32'd1, 32'd3,
                             32'hFFFF_FFFB, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] b  [11] = '{32'd7, 32'd8, 32'd8, 32'd1, 32'hFFFF_FFFF, 32'd3,
                             32'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd2};
    logic        exp[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                             1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] pc;
    logic [31:0] want_pc;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      pc = 32'h1000 + 32'(i * 16);
      want_pc = exp[i] ? 32'h8000 : pc + 32'd4;
      push(pc, exp[i], 32'h8000);
      resolve(1'b1, f3[i], a[i], b[i], 32'h8000);
      checks++;
      if (old_actual !== exp[i] || redirect !== 0 || old_pc !== want_pc) begin
        errors++;
        $display("FAIL cond_%0d got act=%b redir=%b pc=%h want %b 0 %h",
                 i, old_actual, redirect, old_pc, exp[i], want_pc);
      end
    end
    checks++;
    if (err !== 0 || branch_cnt !== 4'd11) begin
      errors++;
      $display("FAIL cond_err got err=%b bc=%0d want 0 11", err, branch_cnt);
    end
    push(32'h2000, 1'b0, 32'h2004);
    resolve(1'b1, 3'b010, 32'd4, 32'd4, 32'h9000);
    checks++;
    if (err !== 1 || old_actual !== 0 || redirect !== 0 || old_pc !== 32'h2004) begin
      errors++;
      $display("FAIL cond_bad_f3 got err=%b act=%b redir=%b pc=%h want 1 0 0 2004",
               err, old_actual, redirect, old_pc);
    end
  endtask

  task automatic test_full();
    logic [31:0] want;
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h10 + 32'(i * 4), 1'b0, 32'h14 + 32'(i * 4));
    checks++;
    if (full !== 1 || err !== 0) begin
      errors++;
      $display("FAIL full_fill got full=%b err=%b want 1 0", full, err);
    end
    push_valid = 1; push_pc = 32'h20; push_predict = 0; push_target = 32'h24;
    resolve(1'b1, 3'b000, 32'd1, 32'd2, 32'h999);
    push_valid = 0;
    checks++;
    if (full !== 1 || old_branch_pc !== 32'h10 || old_pc !== 32'h14 ||
        redirect !== 0 || err !== 0) begin
      errors++;
      $display("FAIL full_pushpop got full=%b bpc=%h pc=%h redir=%b err=%b want 1 10 14 0 0",
               full, old_branch_pc, old_pc, redirect, err);
    end
    push(32'h24, 1'b0, 32'h28);
    checks++;
    if (err !== 1 || full !== 1) begin
      errors++;
      $display("FAIL full_drop got err=%b full=%b want 1 1", err, full);
    end
    for (int i = 0; i < DEPTH; i++) begin
      want = 32'h14 + 32'(i * 4);
      resolve(1'b1, 3'b000, 32'd1, 32'd2, 32'h999);
      checks++;
      if (old_branch_pc !== want || redirect !== 0) begin
        errors++;
        $display("FAIL full_drain_%0d got bpc=%h redir=%b want %h 0",
                 i, old_branch_pc, redirect, want);
      end
    end
    checks++;
    if (full !== 0) begin
      errors++;
      $display("FAIL full_empty got full=%b want 0", full);
    end
  endtask

  task automatic test_wrap_sat();
    do_reset();
    push(32'hFFFF_FFFC, 1'b0, 32'h0);
    resolve(1'b1, 3'b000, 32'd1, 32'd2, 32'h1234);
    checks++;
    if (old_pc !== 32'h0 || old_branch_pc !== 32'hFFFF_FFFC || redirect !== 0) begin
      errors++;
      $display("FAIL wrap got pc=%h bpc=%h redir=%b want 0 fffffffc 0",
               old_pc, old_branch_pc, redirect);
    end
    for (int i = 0; i < 16; i++) begin
      push(32'h400 + 32'(i * 4), 1'b0, 32'h404 + 32'(i * 4));
      resolve(1'b1, 3'b001, 32'd1, 32'd2, 32'h800);
      if (i == 14) begin
        checks++;
        if (miss_cnt !== 4'hF || redirect !== 1) begin
          errors++;
          $display("FAIL sat_15 got mc=%0d redir=%b want 15 1", miss_cnt, redirect);
        end
      end
    end
    checks++;
    if (miss_cnt !== 4'hF || branch_cnt !== 4'hF || redirect !== 1) begin
      errors++;
      $display("FAIL sat_16 got mc=%0d bc=%0d redir=%b want 15 15 1",
               miss_cnt, branch_cnt, redirect);
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    test_reset();
    test_bne_hit();
    test_mispredict_flush();
    test_jalr_target();
    test_conditions();
    test_full();
    test_wrap_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
